adder_chain_pipe: RTL and testbench

- Parametrised successor to the single-bit ADDF adder primitive.
- WIDTH-bit carry-chain adder, segmented into SEG_WIDTH-bit ripple slices with a register after each slice.
- Adds subtract, accumulate and accumulator-clear modes, a valid/ready handshake on both sides, and a signed-overflow flag.
- Sits in the fle physical-mode fabric as the hard arithmetic primitive for wide datapaths.

---
 rtl/adder_chain_pkg.sv | 19 +
 rtl/adder_chain_seg.sv | 32 +++
 rtl/adder_chain_pipe.sv | 150 +++++++++++++++
 tb/tb_adder_chain_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chain_pkg.sv
// rtl/adder_chain_pkg.sv - shared mode encodings and helpers for the segmented adder chain
package adder_chain_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  // Pipeline depth: one register per ripple slice.
  function automatic int latency(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  // ACC and CLR both touch the accumulator and therefore serialise issue.
  function automatic logic uses_acc(input logic [1:0] m);
    return (m == MODE_ACC) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/adder_chain_seg.sv
// rtl/adder_chain_seg.sv - combinational SEG_WIDTH-bit ripple of full-adder cells
module adder_chain_seg
  import adder_chain_pkg::*;
#(
  parameter int SEG_WIDTH = 4
) (
  input  logic [SEG_WIDTH-1:0] seg_a,
  input  logic [SEG_WIDTH-1:0] seg_b,
  input  logic                 seg_cin,
  output logic [SEG_WIDTH-1:0] seg_sum,
  output logic                 seg_cout,
  output logic                 seg_msb_cin
);

  logic [SEG_WIDTH:0] carry;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    carry    = '0;
    seg_sum  = '0;
    carry[0] = seg_cin;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      seg_sum[i]   = seg_a[i] ^ seg_b[i] ^ carry[i];
      carry[i + 1] = (seg_a[i] & seg_b[i]) | (carry[i] & (seg_a[i] ^ seg_b[i]));
    end
  end

  assign seg_cout    = carry[SEG_WIDTH];
  // Carry into the top bit; the final slice uses it for signed overflow.
  assign seg_msb_cin = carry[SEG_WIDTH-1];

endmodule

// File: rtl/adder_chain_pipe.sv
// rtl/adder_chain_pipe.sv - pipelined segmented carry-chain adder with sub/acc/clr modes
module adder_chain_pipe
  import adder_chain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] adder_a,
  input  logic [WIDTH-1:0] adder_b,
  input  logic             adder_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] adder_sumout,
  output logic             adder_cout,
  output logic             adder_ovf,
  output logic [WIDTH-1:0] acc_value
);

  localparam int L  = latency(WIDTH, SEG_WIDTH);
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Stage k inputs (s_*) feed slice k; stage k registers (r_*) hold its results.
  // Each r_a word carries finished sum bits below the slice boundary and
  // not-yet-added operand bits above it.
  logic [WIDTH-1:0]     s_a [L];
  logic [WIDTH-1:0]     s_b [L];
  logic                 s_c [L];
  logic                 s_v [L];
  logic [1:0]           s_m [L];
  logic [SEG_WIDTH-1:0] seg_sum [L];
  logic                 seg_cout [L];
  logic                 seg_msb_cin [L];
  logic [WIDTH-1:0]     r_a [L];
  logic [WIDTH-1:0]     r_b [L];
  logic                 r_c [L];
  logic                 r_v [L];
  logic [1:0]           r_m [L];
  logic                 r_ovf;
  logic [CW-1:0]        acc_inflight;

  logic adv;
  logic accept;
  logic out_hs;
  logic acc_inc;
  logic acc_dec;

  assign out_valid    = r_v[L-1];
  assign adder_sumout = r_a[L-1];
  assign adder_cout   = r_c[L-1];
  assign adder_ovf    = r_ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && (acc_inflight == '0);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign acc_inc  = accept && uses_acc(mode);
  assign acc_dec  = out_hs && uses_acc(r_m[L-1]);

  // Map the mode onto a plain a+b+cin for stage 0; later stages read the previous register.
  always_comb begin
    s_a[0] = adder_a;
    s_b[0] = adder_b;
    s_c[0] = adder_cin;
    case (mode)
      MODE_SUB: s_b[0] = ~adder_b;
      MODE_ACC: begin
        s_a[0] = acc_value;
        s_b[0] = adder_a;
      end
      MODE_CLR: begin
        s_a[0] = '0;
        s_b[0] = '0;
        s_c[0] = 1'b0;
      end
      default: ;
    endcase
    s_v[0] = accept;
    s_m[0] = mode;
    for (int k = 1; k < L; k++) begin
      s_a[k] = r_a[k-1];
      s_b[k] = r_b[k-1];
      s_c[k] = r_c[k-1];
      s_v[k] = r_v[k-1];
      s_m[k] = r_m[k-1];
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_seg
    adder_chain_seg #(
      .SEG_WIDTH (SEG_WIDTH)
    ) u_seg (
      .seg_a       (s_a[k][k*SEG_WIDTH +: SEG_WIDTH]),
      .seg_b       (s_b[k][k*SEG_WIDTH +: SEG_WIDTH]),
      .seg_cin     (s_c[k]),
      .seg_sum     (seg_sum[k]),
      .seg_cout    (seg_cout[k]),
      .seg_msb_cin (seg_msb_cin[k])
    );
  end

  // All stages shift together on adv and freeze together otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < L; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
        r_m[k] <= MODE_ADD;
      end
      r_ovf <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < L; k++) begin
        r_a[k] <= s_a[k];
        r_a[k][k*SEG_WIDTH +: SEG_WIDTH] <= seg_sum[k];
        r_b[k] <= s_b[k];
        r_c[k] <= seg_cout[k];
        r_v[k] <= s_v[k];
        r_m[k] <= s_m[k];
      end
      r_ovf <= seg_cout[L-1] ^ seg_msb_cin[L-1];
    end
  end

  // Accumulator writeback and ACC/CLR in-flight tracking on the handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_value    <= '0;
      acc_inflight <= '0;
    end else begin
      if (out_hs && (r_m[L-1] == MODE_ACC)) begin
        acc_value <= r_a[L-1];
      end else if (out_hs && (r_m[L-1] == MODE_CLR)) begin
        acc_value <= '0;
      end
      if (acc_inc && !acc_dec) begin
        acc_inflight <= acc_inflight + CNT_ONE;
      end else if (acc_dec && !acc_inc) begin
        acc_inflight <= acc_inflight - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_adder_chain_pipe.sv
// tb/tb_adder_chain_pipe.sv - self-checking bench for adder_chain_pipe with a behavioural model
module tb_adder_chain_pipe;
  import adder_chain_pkg::*;

  localparam int W   = 8;
  localparam int S   = 4;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   mode = MODE_ADD;
  logic [W-1:0] adder_a = '0;
  logic [W-1:0] adder_b = '0;
  logic         adder_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] adder_sumout;
  logic         adder_cout;
  logic         adder_ovf;
  logic [W-1:0] acc_value;

  adder_chain_pipe #(
    .WIDTH     (W),
    .SEG_WIDTH (S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .adder_cin    (adder_cin),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .adder_sumout (adder_sumout),
    .adder_cout   (adder_cout),
    .adder_ovf    (adder_ovf),
    .acc_value    (acc_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   m;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  logic [W-1:0] seen_q[$];
  logic [W-1:0] model_acc;
  logic         acc_evt;
  logic         prev_hold;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event within bound want event", name);
  endtask

  // Result of one op from plain integer arithmetic on the operand values.
  function automatic exp_t model_op(input logic [1:0] m, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic c,
                                    input logic [W-1:0] acc);
    exp_t e;
    int   ua, ub, ci, sa, sb, full, sres;
    ci = int'(c);
    case (m)
      MODE_ADD: begin ua = int'(a);   ub = int'(b); end
      MODE_SUB: begin ua = int'(a);   ub = (1 << W) - 1 - int'(b); end
      MODE_ACC: begin ua = int'(acc); ub = int'(a); end
      default:  begin ua = 0; ub = 0; ci = 0; end
    endcase
    full = ua + ub + ci;
    sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sres = sa + sb + ci;
    e.m    = m;
    e.sum  = W'(full);
    e.cout = (full >= (1 << W));
    e.ovf  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    return e;
  endfunction

  function automatic int pending_acc();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].m[1]) n++;
    return n;
  endfunction

  // Compare process: every negedge, check the DUT against the model and advance the model.
  initial begin
    logic exp_ready;
    exp_t e;
    prev_hold = 1'b0;
    acc_evt   = 1'b0;
    model_acc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        model_acc = '0;
        acc_evt   = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_sum", 32'(adder_sumout), 32'(prev_sum));
          chk("hold_cout", 32'(adder_cout), 32'(prev_cout));
          chk("hold_ovf", 32'(adder_ovf), 32'(prev_ovf));
          chk("hold_valid", 32'(out_valid), 32'(1));
        end
        exp_ready = (!out_valid || out_ready) && (pending_acc() == 0);
        chk("in_ready_rule", 32'(in_ready), 32'(exp_ready));
        chk("acc_value", 32'(acc_value), 32'(model_acc));
        if (out_valid) chk("out_valid_has_entry", 32'(exp_q.size() > 0), 32'(1));
        if (out_valid && out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_sum", 32'(adder_sumout), 32'(e.sum));
          chk("res_cout", 32'(adder_cout), 32'(e.cout));
          chk("res_ovf", 32'(adder_ovf), 32'(e.ovf));
          seen_q.push_back(adder_sumout);
          if (e.m == MODE_ACC) model_acc = e.sum;
          if (e.m == MODE_CLR) model_acc = '0;
        end
        acc_evt = in_valid && in_ready;
        if (acc_evt) exp_q.push_back(model_op(mode, adder_a, adder_b, adder_cin, model_acc));
        prev_hold = out_valid && !out_ready;
        prev_sum  = adder_sumout;
        prev_cout = adder_cout;
        prev_ovf  = adder_ovf;
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    int n = 0;
    in_valid  = 1'b1;
    mode      = m;
    adder_a   = a;
    adder_b   = b;
    adder_cin = c;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) timeout_fail("issue_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) timeout_fail("wait_out");
  endtask

  task automatic wait_seen(input int target);
    int n = 0;
    while (seen_q.size() < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (seen_q.size() < target) timeout_fail("wait_seen");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 8'hFF;
      1: return 8'h00;
      2: return 8'h7F;
      3: return 8'h80;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [1:0] pick_mode();
    int r = $urandom_range(0, 9);
    if (r < 4) return MODE_ADD;
    if (r < 8) return MODE_SUB;
    if (r == 8) return MODE_ACC;
    return MODE_CLR;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sum", 32'(adder_sumout), 32'h0);
    chk("rst_cout", 32'(adder_cout), 32'h0);
    chk("rst_ovf", 32'(adder_ovf), 32'h0);
    chk("rst_acc", 32'(acc_value), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // All-ones plus one wraps with carry out, after L cycles.
    issue(MODE_ADD, 8'hFF, 8'h01, 1'b0);
    wait_out(lat);
    chk("wrap_latency", 32'(lat), 32'(LAT));
    chk("wrap_sum", 32'(adder_sumout), 32'h00);
    chk("wrap_cout", 32'(adder_cout), 32'h1);
    chk("wrap_ovf", 32'(adder_ovf), 32'h0);
    @(posedge clk);
    #1;

    issue(MODE_SUB, 8'h05, 8'h07, 1'b1);
    wait_out(lat);
    chk("sub_sum", 32'(adder_sumout), 32'hFE);
    chk("sub_cout", 32'(adder_cout), 32'h0);
    chk("sub_ovf", 32'(adder_ovf), 32'h0);
    @(posedge clk);
    #1;

    issue(MODE_ADD, 8'h7F, 8'h01, 1'b0);
    wait_out(lat);
    chk("ovf_sum", 32'(adder_sumout), 32'h80);
    chk("ovf_flag", 32'(adder_ovf), 32'h1);
    chk("ovf_cout", 32'(adder_cout), 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back ADDs with a 3-cycle downstream stall after the first result.
    base = seen_q.size();
    fork
      begin
        for (int i = 1; i <= 4; i++) issue(MODE_ADD, W'(i), W'(i), 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 50);
        if (!out_valid) timeout_fail("b2b_first_result");
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'h0);
          chk("stall_out_valid", 32'(out_valid), 32'h1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_seen(base + 4);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", 32'(seen_q.size()), 32'(base + 4));
    for (int i = 0; i < 4; i++) begin
      if (base + i < seen_q.size()) chk("b2b_order", 32'(seen_q[base + i]), 32'(2 * (i + 1)));
    end

    // CLR then two ACCs; issue is blocked while each is in flight.
    base = seen_q.size();
    issue(MODE_CLR, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("clr_blocks_issue", 32'(in_ready), 32'h0);
    issue(MODE_ACC, 8'h10, 8'hA5, 1'b0);
    @(negedge clk);
    chk("acc1_blocks_issue", 32'(in_ready), 32'h0);
    issue(MODE_ACC, 8'h20, 8'h5A, 1'b0);
    @(negedge clk);
    chk("acc2_blocks_issue", 32'(in_ready), 32'h0);
    wait_seen(base + 3);
    chk("acc_seq_count", 32'(seen_q.size()), 32'(base + 3));
    if (seen_q.size() >= base + 3) begin
      chk("acc_res_clr", 32'(seen_q[base]), 32'h00);
      chk("acc_res_1", 32'(seen_q[base + 1]), 32'h10);
      chk("acc_res_2", 32'(seen_q[base + 2]), 32'h30);
    end
    chk("acc_final", 32'(acc_value), 32'h30);

    // Reset with two ops in flight and the output stalled.
    out_ready = 1'b0;
    issue(MODE_ADD, 8'h01, 8'h01, 1'b0);
    issue(MODE_ADD, 8'h02, 8'h02, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_acc", 32'(acc_value), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    issue(MODE_ADD, 8'h03, 8'h04, 1'b0);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_sum", 32'(adder_sumout), 32'h07);
    @(posedge clk);
    #1;

    // Randomised traffic; the source may swap a pending op before it is taken.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      reset = (cyc == 1500);
      if (!in_valid || acc_evt || $urandom_range(0, 3) == 0) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        mode      = pick_mode();
        adder_a   = pick_operand();
        adder_b   = pick_operand();
        adder_cin = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
